// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT pointwise-multiply datapath.
// Default sizes match the upstream naiveFNTT block.
package ntt_pkg;

    localparam int NTT_N = 8;
    localparam int NTT_W = 8;

    typedef logic [NTT_W-1:0] coeff_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        REDUCE,
        DONE
    } pmul_state_t;

endpackage

// File: rtl/ntt_modred_step.sv
// One restoring shift-subtract step of a bit-serial modular reduction:
// shift the next product bit into the remainder, subtract mod if it fits.
module ntt_modred_step
    import ntt_pkg::*;
#(
    parameter int W = NTT_W
) (
    input  logic [W:0]   rem,
    input  logic         bit_in,
    input  logic [W-1:0] mod,
    output logic [W:0]   rem_next
);

    logic [W+1:0] t;
    logic [W+1:0] m;

    // Two guard bits keep the compare exact even if rem is not yet below mod.
    always_comb begin
        t        = {rem, bit_in};
        m        = {2'b00, mod};
        rem_next = (W+1)'((t >= m) ? (t - m) : t);
    end

endmodule

// File: rtl/ntt_pointwise_mul.sv
// Sequential pointwise modular multiplier c[i] = a[i]*b[i] mod mod, one element
// at a time, each product reduced over 2W restoring steps.
module ntt_pointwise_mul
    import ntt_pkg::*;
#(
    parameter int N = NTT_N,
    parameter int W = NTT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a [N],
    input  logic [W-1:0] b [N],
    input  logic [W-1:0] mod,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] c [N]
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(2 * W);

    pmul_state_t      state_reg;
    logic [W-1:0]     a_reg [N];
    logic [W-1:0]     b_reg [N];
    logic [W-1:0]     c_reg [N];
    logic [W-1:0]     mod_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2*W-1:0]   prod_reg;
    logic [W:0]       rem_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [W:0]       rem_next;
    logic             capture_en;
    logic             last_step;
    logic             c_wr_en;
    logic [W-1:0]     c_wr_data;

    ntt_modred_step #(.W(W)) u_step (
        .rem      (rem_reg),
        .bit_in   (prod_reg[2*W-1]),
        .mod      (mod_reg),
        .rem_next (rem_next)
    );

    // A modulus of 0 or 1 forces zero results; the schedule is left untouched.
    always_comb begin
        capture_en = (state_reg == IDLE) && start;
        last_step  = (cnt_reg == CNT_W'(2 * W - 1));
        c_wr_en    = (state_reg == REDUCE) && last_step;
        c_wr_data  = (mod_reg <= W'(1)) ? '0 : rem_next[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            mod_reg   <= '0;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            prod_reg  <= '0;
            rem_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        mod_reg   <= mod;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    prod_reg  <= (2*W)'(a_reg[idx_reg]) * (2*W)'(b_reg[idx_reg]);
                    rem_reg   <= '0;
                    cnt_reg   <= '0;
                    state_reg <= REDUCE;
                end
                REDUCE: begin
                    rem_reg  <= rem_next;
                    prod_reg <= prod_reg << 1;
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                    if (last_step) begin
                        if (idx_reg == IDX_W'(N - 1)) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            idx_reg   <= idx_reg + IDX_W'(1);
                            state_reg <= LOAD;
                        end
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elem
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_reg[gi] <= '0;
                    b_reg[gi] <= '0;
                end else if (capture_en) begin
                    a_reg[gi] <= a[gi];
                    b_reg[gi] <= b[gi];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    c_reg[gi] <= '0;
                end else if (c_wr_en && (idx_reg == IDX_W'(gi))) begin
                    c_reg[gi] <= c_wr_data;
                end
            end

            assign c[gi] = c_reg[gi];
        end
    endgenerate

    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_ntt_pointwise_mul.sv
// Scoreboard bench for ntt_pointwise_mul: stimulus pushes reference results,
// a monitor pops and compares on every done pulse.
module tb_ntt_pointwise_mul;
    import ntt_pkg::*;

    localparam int N   = NTT_N;
    localparam int W   = NTT_W;
    localparam int LAT = N * (2 * W + 1);
    localparam int NRAND = 250;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a [N];
    logic [W-1:0] b [N];
    logic [W-1:0] c [N];
    logic [W-1:0] mod;
    logic         busy;
    logic         done;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    logic [N*W-1:0] exp_q [$];
    int             acc_q [$];

    ntt_pointwise_mul #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .mod   (mod),
        .busy  (busy),
        .done  (done),
        .c     (c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic int ref_mul(int x, int y, int m);
        if (m < 2) return 0;
        return (x * y) % m;
    endfunction

    task automatic check(string name, int act, int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Operands and start must already be driven; the next edge is the accept edge.
    task automatic accept_edge();
        logic [N*W-1:0] e;
        for (int i = 0; i < N; i++)
            e[i*W +: W] = W'(ref_mul(int'(a[i]), int'(b[i]), int'(mod)));
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            a[i] = W'($urandom_range(0, 255));
            b[i] = W'($urandom_range(0, 255));
        end
        mod = W'($urandom_range(2, 255));
    endtask

    task automatic single_op();
        start = 1'b1;
        accept_edge();
        start = 1'b0;
        wait_drain();
    endtask

    // Monitor: compares every done pulse against the oldest outstanding request.
    initial begin
        logic [N*W-1:0] e;
        int k;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && done) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL spurious_done: got done=1, expected no outstanding result (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    k = acc_q.pop_front();
                    check("latency", cyc - k, LAT);
                    check("busy_at_done", int'(busy), 0);
                    for (int i = 0; i < N; i++)
                        check($sformatf("c[%0d]", i), int'(c[i]), int'(e[i*W +: W]));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        mod = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        for (int i = 0; i < N; i++) check($sformatf("reset_c[%0d]", i), int'(c[i]), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic mod 17
        for (int i = 0; i < N; i++) begin
            a[i] = W'(i + 1);
            b[i] = W'(16);
        end
        mod = W'(17);
        single_op();
        for (int i = 0; i < N; i++) check($sformatf("basic17_c[%0d]", i), int'(c[i]), 16 - i);

        // Unreduced inputs
        for (int i = 0; i < N; i++) begin
            a[i] = W'(255);
            b[i] = W'(255);
        end
        mod = W'(251);
        single_op();
        for (int i = 0; i < N; i++) check($sformatf("unred251_c[%0d]", i), int'(c[i]), 16);
        mod = W'(17);
        single_op();
        for (int i = 0; i < N; i++) check($sformatf("unred17_c[%0d]", i), int'(c[i]), 0);

        // Degenerate modulus
        for (int m = 1; m >= 0; m--) begin
            for (int i = 0; i < N; i++) begin
                a[i] = W'($urandom_range(1, 255));
                b[i] = W'($urandom_range(1, 255));
            end
            mod = W'(m);
            single_op();
            for (int i = 0; i < N; i++) check($sformatf("mod%0d_c[%0d]", m, i), int'(c[i]), 0);
        end

        // Start while busy: second request must be ignored
        rand_ops();
        start = 1'b1;
        accept_edge();
        start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        rand_ops();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain();
        repeat (150) @(posedge clk);
        #1;

        // Reset mid-operation
        rand_ops();
        start = 1'b1;
        accept_edge();
        start = 1'b0;
        repeat (59) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        acc_q.delete();
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        for (int i = 0; i < N; i++) check($sformatf("midreset_c[%0d]", i), int'(c[i]), 0);
        rst_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        rand_ops();
        single_op();

        // Random back-to-back regression with start held high
        rand_ops();
        start = 1'b1;
        for (int n = 0; n < NRAND; n++) begin
            accept_edge();
            rand_ops();
            if (n == NRAND - 1) start = 1'b0;
            else repeat (LAT + 1) @(posedge clk);
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
